// File: rtl/hpm_pkg.sv
// Hardware performance monitor field layout and event register type.
// Macro HPM_SSCOFPMF_EN enables overflow (OF) and privilege filter bits.
package hpm_pkg;

`ifdef HPM_SSCOFPMF_EN
    localparam bit SSCOF_EN = 1'b1;
`else
    localparam bit SSCOF_EN = 1'b0;
`endif

    localparam int HPM_FIRST   = 3;
    localparam int EVT_OF_BIT  = 63;
    localparam int EVT_MINH    = 62;
    localparam int EVT_SINH    = 61;
    localparam int EVT_UINH    = 60;
    localparam int EVT_SEL_W   = 56;

    typedef struct packed {
        logic                 of;
        logic                 minh;
        logic                 sinh;
        logic                 uinh;
        logic [3:0]           rsvd;
        logic [EVT_SEL_W-1:0] sel;
    } mhpmevent_t;

endpackage

// File: rtl/riscv_pkg.sv
// RISC-V architectural constants shared across the core.
// Holds CSR address bases and privilege-level encodings.
package riscv_pkg;

    localparam logic [1:0] PRIV_LVL_U = 2'b00;
    localparam logic [1:0] PRIV_LVL_S = 2'b01;
    localparam logic [1:0] PRIV_LVL_M = 2'b11;

    localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB00;
    localparam logic [11:0] CSR_MHPMEVENT_BASE   = 12'h320;

endpackage

// File: rtl/hpm_counter_slice.sv
// One mhpmcounter/mhpmevent pair: event select, filter, count, overflow.
// Filter and OF behaviour exist only when HPM_SSCOFPMF_EN is defined.
module hpm_counter_slice
    import riscv_pkg::*;
    import hpm_pkg::*;
#(
    parameter int NUM_EVENTS = 28,
    parameter int CNT_WIDTH  = 48,
    parameter int EVT_INC_W  = 3
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_EVENTS*EVT_INC_W-1:0] events,
    input  logic                            inhibit,
    input  logic [1:0]                      priv_lvl,
    input  logic                            cnt_we,
    input  logic                            evt_we,
    input  logic [63:0]                     wdata,
    output logic [CNT_WIDTH-1:0]            cnt,
    output mhpmevent_t                      evt,
    output logic                            of_set
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    mhpmevent_t           evt_q, evt_d, evt_wr;
    logic [EVT_INC_W-1:0] inc;
    logic                 id_ok;
    logic                 filt_ok;
    logic                 en;
    logic [CNT_WIDTH:0]   sum;
    logic                 ovf;

    // Pick the increment of the selected event id; ids outside 1..N never count
    always_comb begin
        inc   = '0;
        id_ok = 1'b0;
        for (int k = 1; k <= NUM_EVENTS; k++) begin
            if (evt_q.sel == EVT_SEL_W'(k)) begin
                inc   = events[k*EVT_INC_W-1 -: EVT_INC_W];
                id_ok = 1'b1;
            end
        end
    end

    // Privilege filter; inhibit bits stay 0 when the extension is absent
    always_comb begin
        filt_ok = 1'b1;
        unique case (1'b1)
            priv_lvl == PRIV_LVL_M: filt_ok = !evt_q.minh;
            priv_lvl == PRIV_LVL_S: filt_ok = !evt_q.sinh;
            priv_lvl == PRIV_LVL_U: filt_ok = !evt_q.uinh;
            default:                filt_ok = 1'b1;
        endcase
    end

    // Counter next state; a software write overrides the increment
    always_comb begin
        en     = !inhibit && filt_ok && id_ok;
        sum    = (CNT_WIDTH+1)'(cnt_q) + (CNT_WIDTH+1)'(inc);
        ovf    = en && !cnt_we && sum[CNT_WIDTH];
        of_set = SSCOF_EN && ovf && !evt_q.of;
        cnt_d  = cnt_q;
        if (cnt_we) begin
            cnt_d = wdata[CNT_WIDTH-1:0];
        end else if (en) begin
            cnt_d = sum[CNT_WIDTH-1:0];
        end
    end

    // Event register next state; a write beats a same-cycle OF set
    always_comb begin
        evt_wr      = mhpmevent_t'(wdata);
        evt_wr.rsvd = '0;
        evt_wr.of   = evt_wr.of   & SSCOF_EN;
        evt_wr.minh = evt_wr.minh & SSCOF_EN;
        evt_wr.sinh = evt_wr.sinh & SSCOF_EN;
        evt_wr.uinh = evt_wr.uinh & SSCOF_EN;
        evt_d       = evt_q;
        if (evt_we) begin
            evt_d = evt_wr;
        end else if (of_set) begin
            evt_d.of = 1'b1;
        end
    end

    // Counter and event state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign cnt = cnt_q;
    assign evt = evt_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of mhpmcounter3..31 / mhpmevent3..31 with CSR read/write port.
// Define HPM_SSCOFPMF_EN for overflow interrupts and privilege filtering.
module hpm_counter_bank
    import riscv_pkg::*;
    import hpm_pkg::*;
#(
    parameter int NUM_COUNTERS = 29,
    parameter int NUM_EVENTS   = 28,
    parameter int CNT_WIDTH    = 48,
    parameter int EVT_INC_W    = 3
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [11:0]                     addr_i,
    input  logic                            we_i,
    input  logic [63:0]                     data_i,
    output logic [63:0]                     data_o,
    input  logic [31:0]                     mcountinhibit_i,
    input  logic [1:0]                      priv_lvl_i,
    input  logic [NUM_EVENTS*EVT_INC_W-1:0] events_i,
    output logic                            count_ovf_int_req_o,
    output logic [28:0]                     mhpm_ovf_bits_o
);

    logic [NUM_EVENTS*EVT_INC_W-1:0] events_q;
    logic [CNT_WIDTH-1:0]            cnt_arr [NUM_COUNTERS];
    mhpmevent_t                      evt_arr [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]         cnt_we, evt_we, of_set;
    logic [4:0]                      idx;
    logic                            cnt_hit, evt_hit;
    logic                            int_q;
    logic                            unused_inhibit;

    assign idx     = addr_i[4:0];
    assign cnt_hit = addr_i[11:5] == CSR_MHPMCOUNTER_BASE[11:5];
    assign evt_hit = addr_i[11:5] == CSR_MHPMEVENT_BASE[11:5];
    assign unused_inhibit = ^mcountinhibit_i[2:0];

    // One-cycle event pipeline and interrupt pulse register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            events_q <= '0;
            int_q    <= 1'b0;
        end else begin
            events_q <= events_i;
            int_q    <= |of_set;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
        assign cnt_we[i] = we_i && cnt_hit && (idx == 5'(i + HPM_FIRST));
        assign evt_we[i] = we_i && evt_hit && (idx == 5'(i + HPM_FIRST));

        hpm_counter_slice #(
            .NUM_EVENTS (NUM_EVENTS),
            .CNT_WIDTH  (CNT_WIDTH),
            .EVT_INC_W  (EVT_INC_W)
        ) u_slice (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .events   (events_q),
            .inhibit  (mcountinhibit_i[i + HPM_FIRST]),
            .priv_lvl (priv_lvl_i),
            .cnt_we   (cnt_we[i]),
            .evt_we   (evt_we[i]),
            .wdata    (data_i),
            .cnt      (cnt_arr[i]),
            .evt      (evt_arr[i]),
            .of_set   (of_set[i])
        );
    end

    // CSR read mux; writes and unmapped addresses read as zero
    always_comb begin
        data_o = '0;
        if (!we_i) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (idx == 5'(i + HPM_FIRST)) begin
                    if (cnt_hit) data_o = 64'(cnt_arr[i]);
                    if (evt_hit) data_o = 64'(evt_arr[i]);
                end
            end
        end
    end

    // Expose each implemented counter's OF bit
    always_comb begin
        mhpm_ovf_bits_o = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            mhpm_ovf_bits_o[i] = evt_arr[i].of;
        end
    end

    assign count_ovf_int_req_o = int_q;

endmodule
